// File: rtl/seq_serializer_pkg.sv
// Shared types and sizing helpers for the serial front end.
package seq_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam int unsigned SER_WIDTH_DEF = 8;

  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/seq_ser_hold_buf.sv
// One-entry holding register that lets the next word wait while the shifter drains.
module seq_ser_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             unload_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o
);

  logic [WIDTH-1:0] data_q;
  logic             full_q, full_d;

  // load only happens when empty and unload only when full, so they never collide
  always_comb begin
    full_d = full_q;
    if (load_i) begin
      full_d = 1'b1;
    end else if (unload_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_i) begin
      data_q <= data_i;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end for the sequence detectors: MSB first by default,
// LSB first when SEQ_SERIALIZER_LSB_FIRST_EN is defined.
module seq_bit_serializer
  import seq_serializer_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int unsigned     CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d, shifted;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             accept, last, hold_load, hold_unload, out_bit;

  assign din_ready   = !hold_full;
  assign accept      = din_valid && !hold_full;
  assign last        = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign hold_load   = accept && (state_q == SHIFT) && !last;
  assign hold_unload = last && hold_full;

`ifdef SEQ_SERIALIZER_LSB_FIRST_EN
  assign shifted = {1'b0, shift_q[WIDTH-1:1]};
  assign out_bit = shift_q[0];
`else
  assign shifted = {shift_q[WIDTH-2:0], 1'b0};
  assign out_bit = shift_q[WIDTH-1];
`endif

  seq_ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load_i   (hold_load),
    .unload_i (hold_unload),
    .data_i   (din),
    .data_o   (hold_data),
    .full_o   (hold_full)
  );

  // On the last bit the buffered word has priority; din_ready is low then anyway
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shift_d = din;
        end
      end
      SHIFT: begin
        if (!last) begin
          shift_d = shifted;
          cnt_d   = cnt_q + 1'b1;
        end else if (hold_full) begin
          shift_d = hold_data;
          cnt_d   = '0;
        end else if (accept) begin
          shift_d = din;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        shift_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  assign x_valid   = (state_q == SHIFT);
  assign x         = x_valid & out_bit;
  assign busy      = x_valid || hold_full;
  assign word_done = last;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer (WIDTH=8): queue-based reference model plus directed literal checks.
module tb_seq_bit_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready, x, x_valid, busy, word_done;

  int total = 0;
  int bad   = 0;

  seq_bit_serializer #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .x         (x),
    .x_valid   (x_valid),
    .busy      (busy),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bits still to be sent for the current word, and the waiting word.
  bit         cur[$];
  logic [7:0] hold[$];

  function automatic void load_word(input logic [7:0] w);
    cur.delete();
`ifdef SEQ_SERIALIZER_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) cur.push_back(w[i]);
`else
    for (int i = 7; i >= 0; i--) cur.push_back(w[i]);
`endif
  endfunction

  always @(posedge clk) begin
    bit acc, placed;
    if (rst) begin
      cur.delete();
      hold.delete();
    end else begin
      acc    = din_valid && (hold.size() == 0);
      placed = 1'b0;
      if (cur.size() > 0) begin
        void'(cur.pop_front());
        if (cur.size() == 0) begin
          if (hold.size() > 0) begin
            load_word(hold.pop_front());
          end else if (acc) begin
            load_word(din);
            placed = 1'b1;
          end
        end
      end else if (acc) begin
        load_word(din);
        placed = 1'b1;
      end
      if (acc && !placed) hold.push_back(din);
    end
  end

  // Per-cycle compare and serial-stream capture on the falling edge.
  bit chk_en = 1'b0;
  bit cap[$];
  int done_pos[$];
  int cap_cyc = 0, first_vld = -1, last_vld = -1;

  always @(negedge clk) begin
    if (chk_en) begin
      check("x_valid", x_valid, cur.size() > 0);
      check("x", x, (cur.size() > 0) ? cur[0] : 1'b0);
      check("word_done", word_done, cur.size() == 1);
      check("busy", busy, (cur.size() > 0) || (hold.size() > 0));
      check("din_ready", din_ready, hold.size() == 0);
      if (word_done) done_pos.push_back(cap.size());
      if (x_valid) begin
        if (first_vld < 0) first_vld = cap_cyc;
        last_vld = cap_cyc;
        cap.push_back(x);
      end
      cap_cyc++;
    end
  end

  task automatic cap_clear();
    cap.delete();
    done_pos.delete();
    cap_cyc   = 0;
    first_vld = -1;
    last_vld  = -1;
  endtask

  function automatic logic [31:0] cap_vec();
    logic [31:0] v = '0;
    foreach (cap[i]) v = {v[30:0], cap[i]};
    return v;
  endfunction

  task automatic send(input logic [7:0] w);
    int n = 0;
    @(negedge clk);
    din       = w;
    din_valid = 1'b1;
    while (!din_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_0f;

  initial begin
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_x", x, 0);
    check("rst_x_valid", x_valid, 0);
    check("rst_din_ready", din_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_word_done", word_done, 0);
    rst = 1'b0;
    idle(2);

    // Single word A5
    cap_clear();
    send(8'hA5);
    idle(12);
    check("a5_len", cap.size(), 8);
    check("a5_bits", cap_vec(), 32'hA5);
    check("a5_done_cnt", done_pos.size(), 1);
    check("a5_done_pos", (done_pos.size() > 0) ? done_pos[0] : -1, 7);

    // Back-to-back A5, 3C
    cap_clear();
    send(8'hA5);
    send(8'h3C);
    idle(20);
    check("b2b_len", cap.size(), 16);
    check("b2b_bits", cap_vec(), 32'hA53C);
    check("b2b_contig", last_vld - first_vld + 1, 16);
    check("b2b_done_cnt", done_pos.size(), 2);
    check("b2b_done_pos", (done_pos.size() == 2) ? {done_pos[0][15:0], done_pos[1][15:0]} : 0,
          {16'd7, 16'd15});

    // Three words, third waits on back-pressure
    cap_clear();
    send(8'h81);
    send(8'h7E);
    send(8'hC3);
    idle(30);
    check("bp_len", cap.size(), 24);
    check("bp_bits", cap_vec(), 32'h817EC3);
    check("bp_contig", last_vld - first_vld + 1, 24);
    check("bp_done_cnt", done_pos.size(), 3);

    // Reset in cycle 4 of an FF word
    cap_clear();
    send(8'hFF);
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_x", x, 0);
    check("mid_rst_x_valid", x_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_din_ready", din_ready, 1);
    check("mid_rst_word_done", word_done, 0);
    idle(12);
    check("mid_rst_len", cap.size(), 4);
    check("mid_rst_done_cnt", done_pos.size(), 0);

    // Bit order
    cap_clear();
    send(8'h0F);
    idle(12);
`ifdef SEQ_SERIALIZER_LSB_FIRST_EN
    exp_0f = 32'hF0;
`else
    exp_0f = 32'h0F;
`endif
    check("order_len", cap.size(), 8);
    check("order_bits", cap_vec(), exp_0f);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_bit_serializer.md
# seq_bit_serializer

Parallel-to-serial front end for the Moore sequence detectors. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `x`, which drives the detector's serial input directly. A one-entry holding buffer lets consecutive words stream with no idle bit between them. When no word is in flight, `x` is held at 0.

## Interface
- Parameter `WIDTH`, default 8: bits per word; minimum 2.
- `clk` input, 1 bit: single clock; all logic is rising-edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `din` input, WIDTH bits: parallel word.
- `din_valid` input, 1 bit: `din` is valid this cycle.
- `din_ready` output, 1 bit: the block can accept a word this cycle.
- `x` output, 1 bit: serial bit to the detector.
- `x_valid` output, 1 bit: `x` carries a payload bit this cycle.
- `busy` output, 1 bit: the shifter or the holding buffer is occupied.
- `word_done` output, 1 bit: one-cycle pulse during the last bit of each word.

## Operation
- Two-state FSM:
  - IDLE: shifter is empty.
  - SHIFT: shifter holds a word; a bit counter runs 0..WIDTH-1.
- Transfer rule: a word is accepted on any rising edge where `din_valid && din_ready`.
- `din_ready = !hold_full`. It is purely registered state and has no combinational path from `din_valid`.
- Where an accepted word goes:
  - In IDLE, or in SHIFT on the last-bit cycle with the holding buffer empty: the word loads the shifter directly and the counter is cleared to 0.
  - Otherwise: the word loads the holding buffer and `hold_full` is set.
- Last-bit cycle (counter == WIDTH-1):
  - `word_done` = 1.
  - If `hold_full`: the holding buffer moves to the shifter, `hold_full` clears, and the FSM stays in SHIFT.
  - Else, if a word is accepted this cycle: it loads the shifter and the FSM stays in SHIFT.
  - Else: go to IDLE.
- Bit order is MSB first: `x` = `shift[WIDTH-1]` and the shifter shifts left, filling with 0.
- In IDLE: `x` = 0 and `x_valid` = 0.
- `busy` = (state == SHIFT) || `hold_full`.
- Back-pressure: if `din_valid` is held while `din_ready` = 0, the word is accepted on the first edge where `din_ready` = 1. It is never dropped or duplicated.
- Reset mid-word discards the shifter and holding buffer contents. There is no `word_done` for the interrupted word.

## Timing
- Reset values: state IDLE, counter 0, `hold_full` 0, shifter 0. Outputs: `x`=0, `x_valid`=0, `din_ready`=1, `busy`=0, `word_done`=0.
- Latency: a word accepted at edge k shows bit WIDTH-1 on `x` in cycle k+1 and bit 0 in cycle k+WIDTH. `word_done` is high in cycle k+WIDTH.
- Throughput: 1 word per WIDTH cycles with `x_valid` continuously high, provided the next word is accepted by the last-bit edge of the current word.
- After a hold-to-shifter move at edge m, `din_ready` is 1 from cycle m+1.
- All outputs are register-derived. There are no input-to-output combinational paths.

## Configuration
- `SEQ_SERIALIZER_LSB_FIRST_EN`
  - Defined: LSB first. `x` = `shift[0]` and the shifter shifts right, filling with 0.
  - Undefined: MSB first, as described above.
  - Handshake, latency and `word_done` timing are identical in both modes.

## Structure
- Package `seq_serializer_pkg` contains:
  - the state enum (IDLE, SHIFT);
  - default `WIDTH`;
  - function `cnt_w(WIDTH)` = `$clog2(WIDTH)`, used to size the bit counter.
- Sub-module `seq_ser_hold_buf`: the one-entry holding register with its `hold_full` flag, plus load/unload strobes.
- Top level: FSM, shifter and counter.

## Test plan
- Reset, then `din`=8'hA5 accepted at edge 0 (MSB first) -> `x` = 1,0,1,0,0,1,0,1 in cycles 1-8. `x_valid` is high for exactly 8 cycles and `word_done` pulses in cycle 8 only.
- `din_valid` held high with 8'hA5 then 8'h3C -> 16 contiguous `x_valid` cycles with `x` = 10100101 00111100. `din_ready` is low while the hold buffer holds 8'h3C. `word_done` pulses in cycles 8 and 16.
- `din_valid` held for three words while `din_ready` = 0 -> each word is accepted exactly once, no bit is lost, and the serial stream is contiguous.
- `rst` asserted in cycle 4 of an 8'hFF word -> the next cycle shows `x`=0, `x_valid`=0, `busy`=0, `din_ready`=1, with no `word_done`.
- With `SEQ_SERIALIZER_LSB_FIRST_EN` defined, `din`=8'h0F -> `x` = 1,1,1,1,0,0,0,0. With the macro undefined -> `x` = 0,0,0,0,1,1,1,1.
- Integration with the detector: drive 4'b1011 then 4'b0110 with `WIDTH`=4. The detector output must match a reference bitstream applied directly to its `x` input, including the idle-0 cycles.
